msi_dir_ctrl: RTL and testbench
===============================

// Module: msi_dir_ctrl
// PURPOSE
//  L2-side MSI directory controller: the responder for the L1 request channel.
//  Arbitrates L1 requests and snoops sharers/owners, collecting their snoop replies.
//  Returns a grant reply per request and tracks per-line state (I/S/M, sharer mask, owner).
//  Sits under cache_top between the L1 caches and L2 storage; one transaction in flight (blocking).
// PARAMETERS
//  L1_NUM  2  number of L1 caches (requesters)
//  LINE_W  2  line-index width; LINES = 1<<LINE_W directory entries. Message = {op[1:0], line[LINE_W-1:0]}
// PORTS
//  clock               in   1                 sole clock, rising edge
//  reset               in   1                 synchronous, active-high
//  req_up              in   [L1_NUM][2+LINE_W] op: 00 GETS, 01 GETM, 10 PUTM, 11 rsvd
//  req_up_valid        in   [L1_NUM]
//  req_up_ready        out  [L1_NUM]
//  reply_up            out  [L1_NUM][2+LINE_W] op: 00 DATA_S, 01 DATA_M, 10 PUT_ACK, 11 NACK
//  reply_up_valid      out  [L1_NUM]
//  reply_up_ready      in   [L1_NUM]
//  snoop_up            out  [L1_NUM][2+LINE_W] op: 00 INV, 01 FWD_DOWN (M->S), 10 FWD_INV (M->I)
//  snoop_up_valid      out  [L1_NUM]
//  snoop_up_ready      in   [L1_NUM]
//  s_reply_up          in   [L1_NUM][2+LINE_W] op: 00 INV_ACK, 01 DATA_WB
//  s_reply_up_valid    in   [L1_NUM]
//  s_reply_up_ready    out  [L1_NUM]
//  busy                out  1                 state != IDLE
//  proto_err           out  1                 sticky; set on mismatched s_reply line/op
// BEHAVIOUR
//  Handshakes: transfer when valid&&ready. A valid, once raised, holds with stable payload until accepted.
//   Valids never depend on ready.
//  Reset: all valid/ready outputs 0, busy 0, proto_err 0, every line I, sharers 0, owner 0, rr_ptr 0.
//   Reset mid-transaction aborts it; outputs are 0 from the next cycle.
//  FSM: IDLE -> LOOKUP -> (SNOOP ->) REPLY -> IDLE.
//  IDLE: round-robin grant among req_up_valid, starting at rr_ptr.
//   req_up_ready[g]=1 for the winner only, combinationally in IDLE.
//   On accept, latch req id/op/line, set rr_ptr=(g+1)%L1_NUM, go to LOOKUP.
//  LOOKUP (1 cycle), per latched op and line state:
//   GETS: I/S -> reply DATA_S. M, owner!=req -> FWD_DOWN to owner. M, owner==req -> NACK.
//   GETM: I -> DATA_M. S -> INV to sharers & ~req (none left -> DATA_M directly).
//    M, owner!=req -> FWD_INV to owner. M, owner==req -> NACK.
//   PUTM: M and owner==req -> PUT_ACK. Otherwise NACK (stale put). rsvd op -> NACK.
//   Empty snoop set -> REPLY, else load pend=target mask, acked=0 -> SNOOP.
//  SNOOP: snoop_up_valid[i]=pend[i], all in parallel; clear pend[i] on handshake.
//   s_reply_up_ready[i]=issued[i]&~acked[i], where issued = targets accepted in an earlier cycle.
//   No ack is accepted in the snoop handshake cycle.
//   s_reply from a non-expected L1 is never accepted (ready 0).
//   Expected reply with wrong line, or wrong op (INV->DATA_WB, FWD->INV_ACK): count it as ack, set proto_err.
//   When pend==0 and acked==targets, go to REPLY next cycle.
//  REPLY: reply_up_valid[req]=1 with {op,line}. Directory updates on the handshake, then IDLE:
//   DATA_S: state S, sharers|=req, plus old owner if downgraded; owner cleared.
//   DATA_M: state M, owner=req, sharers=1<<req.
//   PUT_ACK: state I, sharers=0. NACK: no change.
//  Latency: req accepted at cycle N -> reply_up_valid at N+2 (no snoop). Snoop valid at N+2.
//   Reply valid at cycle after the last ack accepted.
//  Backpressure: no req accepted while busy. Lookups use the updated directory (no bypass hazard).
// TESTING (L1_NUM=2, LINE_W=2)
//  1. After reset, L1-0 req 4'b0001 (GETS L1) -> reply_up[0]=4'b0001 at N+2, no snoop.
//     Line1=S, sharers=2'b01.
//  2. Both L1s GETM line2 same cycle, rr_ptr=0 -> L1-0 granted, reply 4'b0110. Then L1-1 granted:
//     snoop_up[0]=4'b1010 -> s_reply 4'b0110 -> reply_up[1]=4'b0110, owner=1.
//  3. Line0 shared by both, L1-1 req 4'b0100 -> snoop_up[0]=4'b0000 only.
//     After INV_ACK 4'b0000, reply_up[1]=4'b0100. Line0=M, owner=1.
//  4. PUTM line3 (4'b1011) from non-owner -> reply 4'b1111, state unchanged.
//     From owner -> reply 4'b1011, line3=I.
//  5. reply_up_ready=0 for 5 cycles -> reply valid and payload stable, req_up_ready all 0.
//     Accepted on cycle 6, then IDLE.
//  6. Unexpected s_reply from L1-1 -> ready 0, no state change. Wrong-line ack -> proto_err=1.
//     Reset in SNOOP -> next cycle all valids 0, all lines I.

Source files
------------

// File: rtl/msi_dir_ctrl.sv
// MSI directory: round-robin L1 request grant, snoop of sharers/owner, one blocking transaction.
// Reply 2 cycles after accept (no snoop) or 1 cycle after last ack; requests stall while busy.
module msi_dir_ctrl #(
    parameter int L1_NUM = 2,
    parameter int LINE_W = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [L1_NUM-1:0][LINE_W+1:0] req_up,
    input  logic [L1_NUM-1:0]             req_up_valid,
    output logic [L1_NUM-1:0]             req_up_ready,
    output logic [L1_NUM-1:0][LINE_W+1:0] reply_up,
    output logic [L1_NUM-1:0]             reply_up_valid,
    input  logic [L1_NUM-1:0]             reply_up_ready,
    output logic [L1_NUM-1:0][LINE_W+1:0] snoop_up,
    output logic [L1_NUM-1:0]             snoop_up_valid,
    input  logic [L1_NUM-1:0]             snoop_up_ready,
    input  logic [L1_NUM-1:0][LINE_W+1:0] s_reply_up,
    input  logic [L1_NUM-1:0]             s_reply_up_valid,
    output logic [L1_NUM-1:0]             s_reply_up_ready,
    output logic                          busy,
    output logic                          proto_err
);

    localparam int LINES = 1 << LINE_W;
    localparam int ID_W  = (L1_NUM > 1) ? $clog2(L1_NUM) : 1;

    localparam logic [1:0] OP_GETS     = 2'b00;
    localparam logic [1:0] OP_GETM     = 2'b01;
    localparam logic [1:0] OP_PUTM     = 2'b10;
    localparam logic [1:0] RP_DATA_S   = 2'b00;
    localparam logic [1:0] RP_DATA_M   = 2'b01;
    localparam logic [1:0] RP_PUT_ACK  = 2'b10;
    localparam logic [1:0] RP_NACK     = 2'b11;
    localparam logic [1:0] SN_INV      = 2'b00;
    localparam logic [1:0] SN_FWD_DOWN = 2'b01;
    localparam logic [1:0] SN_FWD_INV  = 2'b10;
    localparam logic [1:0] SR_INV_ACK  = 2'b00;
    localparam logic [1:0] SR_DATA_WB  = 2'b01;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_SNOOP, ST_REPLY} state_t;
    typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

    state_t                           state_q, state_d;
    logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]                  req_id_q, req_id_d;
    logic [1:0]                       req_op_q, req_op_d;
    logic [LINE_W-1:0]                req_line_q, req_line_d;
    logic [1:0]                       rep_op_q, rep_op_d;
    logic [1:0]                       snp_op_q, snp_op_d;
    logic                             dngrade_q, dngrade_d;
    logic [L1_NUM-1:0]                targets_q, targets_d;
    logic [L1_NUM-1:0]                pend_q, pend_d;
    logic [L1_NUM-1:0]                issued_q, issued_d;
    logic [L1_NUM-1:0]                acked_q, acked_d;
    logic                             proto_err_q, proto_err_d;
    line_t                            dir_st_q [LINES];
    line_t                            dir_st_d [LINES];
    logic [ID_W-1:0]                  owner_q [LINES];
    logic [ID_W-1:0]                  owner_d [LINES];
    logic [LINES-1:0][L1_NUM-1:0]     sharers_q, sharers_d;

    logic                             found;
    int                               gnt;
    int                               idx;
    line_t                            cur_st;
    logic [ID_W-1:0]                  cur_own;
    logic [L1_NUM-1:0]                req_mask;
    logic [L1_NUM-1:0]                own_mask;
    logic [L1_NUM-1:0]                tgt;
    logic [1:0]                       rep;
    logic [1:0]                       snp;
    logic [1:0]                       exp_sr;

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        req_id_d         = req_id_q;
        req_op_d         = req_op_q;
        req_line_d       = req_line_q;
        rep_op_d         = rep_op_q;
        snp_op_d         = snp_op_q;
        dngrade_d        = dngrade_q;
        targets_d        = targets_q;
        pend_d           = pend_q;
        issued_d         = issued_q;
        acked_d          = acked_q;
        proto_err_d      = proto_err_q;
        dir_st_d         = dir_st_q;
        owner_d          = owner_q;
        sharers_d        = sharers_q;
        req_up_ready     = '0;
        reply_up         = '0;
        reply_up_valid   = '0;
        snoop_up         = '0;
        snoop_up_valid   = '0;
        s_reply_up_ready = '0;
        found            = 1'b0;
        gnt              = 0;
        idx              = 0;
        cur_st           = dir_st_q[req_line_q];
        cur_own          = owner_q[req_line_q];
        req_mask         = '0;
        req_mask[req_id_q] = 1'b1;
        own_mask         = '0;
        own_mask[cur_own]  = 1'b1;
        tgt              = '0;
        rep              = RP_NACK;
        snp              = SN_INV;
        exp_sr           = SR_INV_ACK;

        case (state_q)
            ST_IDLE: begin
                for (int k = 0; k < L1_NUM; k++) begin
                    idx = (int'(rr_ptr_q) + k) % L1_NUM;
                    if (!found && req_up_valid[idx]) begin
                        found = 1'b1;
                        gnt   = idx;
                    end
                end
                if (found) begin
                    req_up_ready[gnt] = 1'b1;
                    req_id_d   = ID_W'(gnt);
                    req_op_d   = req_up[gnt][LINE_W+1:LINE_W];
                    req_line_d = req_up[gnt][LINE_W-1:0];
                    rr_ptr_d   = ID_W'((gnt + 1) % L1_NUM);
                    state_d    = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                case (req_op_q)
                    OP_GETS: begin
                        if (cur_st != LN_M) begin
                            rep = RP_DATA_S;
                        end else if (cur_own != req_id_q) begin
                            tgt = own_mask;
                            snp = SN_FWD_DOWN;
                            rep = RP_DATA_S;
                        end
                    end
                    OP_GETM: begin
                        if (cur_st == LN_I) begin
                            rep = RP_DATA_M;
                        end else if (cur_st == LN_S) begin
                            // Requester keeps its own copy; only the other sharers are invalidated.
                            tgt = sharers_q[req_line_q] & ~req_mask;
                            rep = RP_DATA_M;
                        end else if (cur_own != req_id_q) begin
                            tgt = own_mask;
                            snp = SN_FWD_INV;
                            rep = RP_DATA_M;
                        end
                    end
                    OP_PUTM: begin
                        if (cur_st == LN_M && cur_own == req_id_q) begin
                            rep = RP_PUT_ACK;
                        end
                    end
                    default: rep = RP_NACK;
                endcase
                rep_op_d  = rep;
                snp_op_d  = snp;
                dngrade_d = (snp == SN_FWD_DOWN) && (tgt != '0);
                targets_d = tgt;
                pend_d    = tgt;
                issued_d  = '0;
                acked_d   = '0;
                state_d   = (tgt == '0) ? ST_REPLY : ST_SNOOP;
            end

            ST_SNOOP: begin
                snoop_up_valid   = pend_q;
                s_reply_up_ready = issued_q & ~acked_q;
                exp_sr = (snp_op_q == SN_INV) ? SR_INV_ACK : SR_DATA_WB;
                for (int i = 0; i < L1_NUM; i++) begin
                    snoop_up[i] = {snp_op_q, req_line_q};
                    if (pend_q[i] && snoop_up_ready[i]) begin
                        pend_d[i]   = 1'b0;
                        issued_d[i] = 1'b1;
                    end
                    // A malformed reply still closes out that target so the transaction cannot wedge.
                    if (issued_q[i] && !acked_q[i] && s_reply_up_valid[i]) begin
                        acked_d[i] = 1'b1;
                        if (s_reply_up[i][LINE_W+1:LINE_W] != exp_sr ||
                            s_reply_up[i][LINE_W-1:0] != req_line_q) begin
                            proto_err_d = 1'b1;
                        end
                    end
                end
                if (pend_d == '0 && acked_d == targets_q) begin
                    state_d = ST_REPLY;
                end
            end

            ST_REPLY: begin
                reply_up_valid[req_id_q] = 1'b1;
                reply_up[req_id_q]       = {rep_op_q, req_line_q};
                if (reply_up_ready[req_id_q]) begin
                    state_d = ST_IDLE;
                    case (rep_op_q)
                        RP_DATA_S: begin
                            dir_st_d[req_line_q]  = LN_S;
                            sharers_d[req_line_q] = sharers_q[req_line_q] | req_mask |
                                                    (dngrade_q ? own_mask : '0);
                            owner_d[req_line_q]   = '0;
                        end
                        RP_DATA_M: begin
                            dir_st_d[req_line_q]  = LN_M;
                            sharers_d[req_line_q] = req_mask;
                            owner_d[req_line_q]   = req_id_q;
                        end
                        RP_PUT_ACK: begin
                            dir_st_d[req_line_q]  = LN_I;
                            sharers_d[req_line_q] = '0;
                            owner_d[req_line_q]   = '0;
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            req_id_q    <= '0;
            req_op_q    <= '0;
            req_line_q  <= '0;
            rep_op_q    <= '0;
            snp_op_q    <= '0;
            dngrade_q   <= 1'b0;
            targets_q   <= '0;
            pend_q      <= '0;
            issued_q    <= '0;
            acked_q     <= '0;
            proto_err_q <= 1'b0;
            sharers_q   <= '0;
            for (int l = 0; l < LINES; l++) begin
                dir_st_q[l] <= LN_I;
                owner_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            req_id_q    <= req_id_d;
            req_op_q    <= req_op_d;
            req_line_q  <= req_line_d;
            rep_op_q    <= rep_op_d;
            snp_op_q    <= snp_op_d;
            dngrade_q   <= dngrade_d;
            targets_q   <= targets_d;
            pend_q      <= pend_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            proto_err_q <= proto_err_d;
            sharers_q   <= sharers_d;
            dir_st_q    <= dir_st_d;
            owner_q     <= owner_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_msi_dir_ctrl.sv
// Directed bench for msi_dir_ctrl (2 L1s, 4 lines); directory state is tracked by hand and
// confirmed through later transactions' replies and snoops.
module tb_msi_dir_ctrl;

    localparam int L1_NUM = 2;
    localparam int LINE_W = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0][3:0]  req_up;
    logic [1:0]       req_up_valid;
    logic [1:0]       req_up_ready;
    logic [1:0][3:0]  reply_up;
    logic [1:0]       reply_up_valid;
    logic [1:0]       reply_up_ready;
    logic [1:0][3:0]  snoop_up;
    logic [1:0]       snoop_up_valid;
    logic [1:0]       snoop_up_ready;
    logic [1:0][3:0]  s_reply_up;
    logic [1:0]       s_reply_up_valid;
    logic [1:0]       s_reply_up_ready;
    logic             busy;
    logic             proto_err;

    int vec  = 0;
    int errs = 0;

    msi_dir_ctrl #(.L1_NUM(L1_NUM), .LINE_W(LINE_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_up           (req_up),
        .req_up_valid     (req_up_valid),
        .req_up_ready     (req_up_ready),
        .reply_up         (reply_up),
        .reply_up_valid   (reply_up_valid),
        .reply_up_ready   (reply_up_ready),
        .snoop_up         (snoop_up),
        .snoop_up_valid   (snoop_up_valid),
        .snoop_up_ready   (snoop_up_ready),
        .s_reply_up       (s_reply_up),
        .s_reply_up_valid (s_reply_up_valid),
        .s_reply_up_ready (s_reply_up_ready),
        .busy             (busy),
        .proto_err        (proto_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: obs = {ready seen, reply valid mask, reply msg, snoop mask, snoop msg, latency}.
    task automatic xact(input int id, input logic [3:0] msg, input logic [3:0] sresp,
                        output logic [16:0] obs);
        logic       rdy;
        logic       seen;
        logic [1:0] smask, rv, hs;
        logic [3:0] smsg, rmsg, lat;
        rdy = 1'b0; seen = 1'b0; smask = '0; rv = '0; smsg = '0; rmsg = '0; lat = 4'hf;
        req_up[id] = msg;
        req_up_valid[id] = 1'b1;
        #1;
        rdy = req_up_ready[id];
        step();
        req_up_valid[id] = 1'b0;
        for (int c = 1; c < 15; c++) begin
            if (reply_up_valid != 2'b00) begin
                rv   = reply_up_valid;
                rmsg = reply_up[id];
                lat  = 4'(c);
                step();
                break;
            end
            if (!seen && snoop_up_valid != 2'b00) begin
                seen  = 1'b1;
                smask = snoop_up_valid;
                for (int i = L1_NUM - 1; i >= 0; i--) begin
                    if (smask[i]) begin
                        smsg = snoop_up[i];
                        s_reply_up[i] = sresp;
                        s_reply_up_valid[i] = 1'b1;
                    end
                end
            end
            hs = s_reply_up_valid & s_reply_up_ready;
            step();
            s_reply_up_valid = s_reply_up_valid & ~hs;
        end
        s_reply_up_valid = '0;
        obs = {rdy, rv, rmsg, smask, smsg, lat};
    endtask

    task automatic test_reset();
        logic [10:0] o;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        o = {busy, proto_err, req_up_ready, reply_up_valid, snoop_up_valid, s_reply_up_ready};
        vec++;
        if (o !== 11'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %b want %b", o, 11'd0);
        end
    endtask

    task automatic test_gets();
        logic [16:0] obs, exp;
        xact(0, 4'b0001, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b0001, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL gets_l0_line1: got %h want %h", obs, exp); end
        xact(1, 4'b0001, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b0001, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL gets_l1_line1: got %h want %h", obs, exp); end
    endtask

    task automatic test_arbitration();
        logic [16:0] obs, exp;
        logic [7:0]  o;
        req_up[0] = 4'b0110; req_up[1] = 4'b0110; req_up_valid = 2'b11;
        #1;
        vec++;
        if (req_up_ready !== 2'b01) begin errs++; $display("FAIL arb_grant0: got %b want 01", req_up_ready); end
        step();
        req_up_valid[0] = 1'b0;
        o = {5'd0, busy, req_up_ready};
        vec++;
        if (o !== 8'b0000_0100) begin errs++; $display("FAIL arb_busy_block: got %b want 00000100", o); end
        step();
        o = {2'b00, reply_up_valid, reply_up[0]};
        vec++;
        if (o !== 8'b0001_0110) begin errs++; $display("FAIL arb_reply0: got %b want 00010110", o); end
        step();
        vec++;
        if (req_up_ready !== 2'b10) begin errs++; $display("FAIL arb_grant1: got %b want 10", req_up_ready); end
        step();
        req_up_valid[1] = 1'b0;
        step();
        o = {snoop_up_valid, snoop_up[0], s_reply_up_ready};
        vec++;
        if (o !== 8'b01_1010_00 || reply_up_valid !== 2'b00) begin
            errs++; $display("FAIL arb_fwd_inv: got %b rv %b want 01101000 rv 00", o, reply_up_valid);
        end
        s_reply_up[0] = 4'b0110; s_reply_up_valid[0] = 1'b1;
        step();
        o = {4'd0, snoop_up_valid, s_reply_up_ready};
        vec++;
        if (o !== 8'b0000_0001) begin errs++; $display("FAIL arb_ack_window: got %b want 00000001", o); end
        step();
        s_reply_up_valid[0] = 1'b0;
        o = {2'b00, reply_up_valid, reply_up[1]};
        vec++;
        if (o !== 8'b0010_0110) begin errs++; $display("FAIL arb_reply1: got %b want 00100110", o); end
        step();
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL arb_idle: got %b want 0", busy); end
        // line2 now owned by L1-1: its own GETS must be refused
        xact(1, 4'b0010, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b1110, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL owner_gets_nack: got %h want %h", obs, exp); end
    endtask

    task automatic test_shared_upgrade();
        logic [16:0] obs, exp;
        xact(0, 4'b0000, 4'b0000, obs);
        xact(1, 4'b0000, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b0000, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL share_line0: got %h want %h", obs, exp); end
        xact(1, 4'b0100, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b0100, 2'b01, 4'b0000, 4'd4};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL upgrade_inv: got %h want %h", obs, exp); end
        xact(0, 4'b0000, 4'b0100, obs);
        exp = {1'b1, 2'b01, 4'b0000, 2'b10, 4'b0100, 4'd4};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL fwd_down: got %h want %h", obs, exp); end
        xact(0, 4'b0100, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b0100, 2'b10, 4'b0000, 4'd4};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL downgrade_sharers: got %h want %h", obs, exp); end
    endtask

    task automatic test_putm();
        logic [16:0] obs, exp;
        xact(0, 4'b0111, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b0111, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL getm_line3: got %h want %h", obs, exp); end
        xact(1, 4'b1011, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b1111, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL putm_nonowner: got %h want %h", obs, exp); end
        xact(0, 4'b1011, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b1011, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL putm_owner: got %h want %h", obs, exp); end
        xact(0, 4'b1011, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b1111, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL putm_stale: got %h want %h", obs, exp); end
    endtask

    task automatic test_backpressure();
        logic [7:0] o;
        reply_up_ready = 2'b00;
        req_up[0] = 4'b0001; req_up_valid[0] = 1'b1;
        step();
        req_up_valid[0] = 1'b0;
        req_up[1] = 4'b0001; req_up_valid[1] = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) reply_up_ready = 2'b11;
            #1;
            o = {reply_up_valid, reply_up[0], req_up_ready};
            vec++;
            if (o !== 8'b01_0001_00) begin
                errs++; $display("FAIL stall_cycle%0d: got %b want 01000100", k, o);
            end
            step();
        end
        o = {5'd0, busy, req_up_ready};
        vec++;
        if (o !== 8'b0000_0010) begin errs++; $display("FAIL stall_release: got %b want 00000010", o); end
        step();
        req_up_valid[1] = 1'b0;
        step();
        o = {2'b00, reply_up_valid, reply_up[1]};
        vec++;
        if (o !== 8'b0010_0001) begin errs++; $display("FAIL queued_reply: got %b want 00100001", o); end
        step();
    endtask

    task automatic test_snoop_errors_and_reset();
        logic [16:0] obs, exp;
        logic [9:0]  o;
        req_up[1] = 4'b0101; req_up_valid[1] = 1'b1;
        step();
        req_up_valid[1] = 1'b0;
        step();
        o = {4'd0, snoop_up_valid, snoop_up[0]};
        vec++;
        if (o !== 10'b0000_01_0001) begin errs++; $display("FAIL err_snoop: got %b want 0000010001", o); end
        s_reply_up[1] = 4'b0001; s_reply_up_valid[1] = 1'b1;
        step();
        o = {7'd0, s_reply_up_ready, proto_err};
        vec++;
        if (o !== 10'b000000_0010) begin errs++; $display("FAIL unexpected_ready: got %b want 0000000010", o); end
        s_reply_up[0] = 4'b0010; s_reply_up_valid[0] = 1'b1;
        step();
        s_reply_up_valid[0] = 1'b0;
        o = {1'b0, s_reply_up_ready, reply_up_valid, reply_up[1], proto_err};
        vec++;
        if (o !== 10'b0_00_10_0101_1) begin errs++; $display("FAIL wrong_line_ack: got %b want 0001001011", o); end
        step();
        s_reply_up_valid[1] = 1'b0;
        o = {8'd0, busy, proto_err};
        vec++;
        if (o !== 10'b00000000_01) begin errs++; $display("FAIL proto_sticky: got %b want 0000000001", o); end

        req_up[0] = 4'b0010; req_up_valid[0] = 1'b1;
        step();
        req_up_valid[0] = 1'b0;
        step();
        o = {4'd0, snoop_up_valid, snoop_up[1]};
        vec++;
        if (o !== 10'b0000_10_0110) begin errs++; $display("FAIL fwd_down_pre_reset: got %b want 0000100110", o); end
        reset = 1'b1;
        step();
        o = {snoop_up_valid, reply_up_valid, s_reply_up_ready, req_up_ready, busy, proto_err};
        vec++;
        if (o !== 10'd0) begin errs++; $display("FAIL reset_in_snoop: got %b want 0000000000", o); end
        reset = 1'b0;
        xact(0, 4'b0110, 4'b0000, obs);
        exp = {1'b1, 2'b01, 4'b0110, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL post_reset_line2_I: got %h want %h", obs, exp); end
        xact(1, 4'b1000, 4'b0000, obs);
        exp = {1'b1, 2'b10, 4'b1100, 2'b00, 4'b0000, 4'd2};
        vec++;
        if (obs !== exp) begin errs++; $display("FAIL post_reset_line0_I: got %h want %h", obs, exp); end
    endtask

    initial begin
        reset            = 1'b1;
        req_up           = '0;
        req_up_valid     = '0;
        reply_up_ready   = 2'b11;
        snoop_up_ready   = 2'b11;
        s_reply_up       = '0;
        s_reply_up_valid = '0;
        test_reset();
        test_gets();
        test_arbitration();
        test_shared_upgrade();
        test_putm();
        test_backpressure();
        test_snoop_errors_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
        $fatal(1);
    end

endmodule
